// File: rtl/step_clock_ctrl_if.sv
// Front-panel inputs and 74HCT74 control pins of step_clock_ctrl.
// preset_req exists only when STEP_CLOCK_PRESET_EN is defined.
interface step_clock_ctrl_if;
    logic       run_btn;
    logic       step_btn;
    logic       halt_req;
`ifdef STEP_CLOCK_PRESET_EN
    logic       preset_req;
`endif
    logic       cp;
    logic       _rd;
    logic       _sd;
    logic       running;
    logic [7:0] step_count;

`ifdef STEP_CLOCK_PRESET_EN
    modport master (
        output run_btn, step_btn, halt_req, preset_req,
        input  cp, _rd, _sd, running, step_count
    );
    modport slave (
        input  run_btn, step_btn, halt_req, preset_req,
        output cp, _rd, _sd, running, step_count
    );
`else
    modport master (
        output run_btn, step_btn, halt_req,
        input  cp, _rd, _sd, running, step_count
    );
    modport slave (
        input  run_btn, step_btn, halt_req,
        output cp, _rd, _sd, running, step_count
    );
`endif
endinterface

// File: rtl/step_clock_ctrl.sv
// Clock/reset sequencer driving CP, _RD and _SD of a 74HCT74 stage from panel buttons.
// Define STEP_CLOCK_PRESET_EN to add the preset_req input and its one-clock _SD pulse.
module step_clock_ctrl #(
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned DEBOUNCE     = 3
) (
    input logic              clk,
    input logic              reset,
    step_clock_ctrl_if.slave bus
);

    typedef enum logic [2:0] {StInit, StIdle, StRun, StStep, StHalted} state_e;

    localparam logic [3:0] DebLast  = 4'(DEBOUNCE - 1);
    localparam logic [7:0] InitLast = 8'(RESET_CYCLES - 1);

    // Button bit 0 is run, bit 1 is step.
    logic [1:0]      sync1_q, sync1_d;
    logic [1:0]      sync2_q, sync2_d;
    logic [1:0]      deb_q, deb_d;
    logic [1:0][3:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]      press;
    logic            run_press, step_press;

    state_e     state_q, state_d;
    logic       cp_q, cp_d;
    logic       rd_n_q, rd_n_d;
    logic       sd_n_q, sd_n_d;
    logic       running_q, running_d;
    logic [7:0] step_count_q, step_count_d;
    logic [7:0] init_cnt_q, init_cnt_d;
    logic       stop_pend_q, stop_pend_d;
    logic       halt_pend_q, halt_pend_d;
    logic       stop_now, halt_now;
    logic       preset_edge;

`ifdef STEP_CLOCK_PRESET_EN
    logic preset_prev_q, preset_prev_d;
    assign preset_prev_d = bus.preset_req;
    assign preset_edge   = bus.preset_req & ~preset_prev_q;
`else
    assign preset_edge = 1'b0;
`endif

    // Debounced level flips after DEBOUNCE consecutive samples disagreeing with it.
    always_comb begin
        sync1_d   = {bus.step_btn, bus.run_btn};
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        deb_cnt_d = '0;
        press     = '0;
        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] != deb_q[b]) begin
                if (deb_cnt_q[b] == DebLast) begin
                    deb_d[b] = sync2_q[b];
                    press[b] = sync2_q[b];
                end else begin
                    deb_cnt_d[b] = deb_cnt_q[b] + 4'd1;
                end
            end
        end
    end

    assign run_press  = press[0];
    assign step_press = press[1];

    always_comb begin
        state_d     = state_q;
        cp_d        = 1'b0;
        rd_n_d      = 1'b1;
        sd_n_d      = 1'b1;
        init_cnt_d  = init_cnt_q;
        stop_pend_d = 1'b0;
        halt_pend_d = 1'b0;
        stop_now    = 1'b0;
        halt_now    = 1'b0;

        unique case (state_q)
            StInit: begin
                rd_n_d = 1'b0;
                if (init_cnt_q == InitLast) begin
                    state_d = StIdle;
                    rd_n_d  = 1'b1;
                end else begin
                    init_cnt_d = init_cnt_q + 8'd1;
                end
            end
            StIdle: begin
                if (preset_edge) begin
                    sd_n_d = 1'b0;
                end else if (run_press) begin
                    state_d = StRun;
                    cp_d    = 1'b1;
                end else if (step_press) begin
                    state_d = StStep;
                    cp_d    = 1'b1;
                end
            end
            StRun: begin
                stop_now = stop_pend_q | run_press;
                halt_now = halt_pend_q | bus.halt_req;
                // Requests only take effect on a falling cp edge so no high phase is cut short.
                if (cp_q) begin
                    if (halt_now) begin
                        state_d = StHalted;
                    end else if (stop_now) begin
                        state_d = StIdle;
                    end
                end else begin
                    cp_d        = 1'b1;
                    stop_pend_d = stop_now;
                    halt_pend_d = halt_now;
                end
            end
            StStep: begin
                state_d = StIdle;
            end
            StHalted: begin
                if (preset_edge) begin
                    sd_n_d = 1'b0;
                end else if (run_press && !bus.halt_req) begin
                    state_d = StRun;
                    cp_d    = 1'b1;
                end else if (step_press) begin
                    state_d = StStep;
                    cp_d    = 1'b1;
                end
            end
            default: begin
                state_d = StInit;
                rd_n_d  = 1'b0;
            end
        endcase

        running_d    = (state_d == StRun);
        step_count_d = step_count_q;
        if (cp_d && !cp_q) begin
            step_count_d = step_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            deb_q         <= '0;
            deb_cnt_q     <= '0;
            state_q       <= StInit;
            cp_q          <= 1'b0;
            rd_n_q        <= 1'b0;
            sd_n_q        <= 1'b1;
            running_q     <= 1'b0;
            step_count_q  <= '0;
            init_cnt_q    <= '0;
            stop_pend_q   <= 1'b0;
            halt_pend_q   <= 1'b0;
`ifdef STEP_CLOCK_PRESET_EN
            preset_prev_q <= 1'b0;
`endif
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            deb_q         <= deb_d;
            deb_cnt_q     <= deb_cnt_d;
            state_q       <= state_d;
            cp_q          <= cp_d;
            rd_n_q        <= rd_n_d;
            sd_n_q        <= sd_n_d;
            running_q     <= running_d;
            step_count_q  <= step_count_d;
            init_cnt_q    <= init_cnt_d;
            stop_pend_q   <= stop_pend_d;
            halt_pend_q   <= halt_pend_d;
`ifdef STEP_CLOCK_PRESET_EN
            preset_prev_q <= preset_prev_d;
`endif
        end
    end

    assign bus.cp         = cp_q;
    assign bus._rd        = rd_n_q;
    assign bus._sd        = sd_n_q;
    assign bus.running    = running_q;
    assign bus.step_count = step_count_q;

    // Clear and preset low together would force Q and /Q high in the 7474.
    a_no_rd_sd_low: assert property (@(posedge clk) disable iff (reset) (rd_n_q || sd_n_q));

endmodule

// File: tb/tb_step_clock_ctrl.sv
// Bench for step_clock_ctrl: directed panel scenarios plus random buttons/halt/reset,
// each cycle compared with an event-level model of the sequencer rules.
module tb_step_clock_ctrl;
    localparam int unsigned RC = 4;
    localparam int unsigned DB = 3;
    localparam int MInit = 0, MIdle = 1, MRun = 2, MStep = 3, MHalt = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    step_clock_ctrl_if ifc ();

    step_clock_ctrl #(
        .RESET_CYCLES(RC),
        .DEBOUNCE    (DB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc)
    );

    always #5 clk = ~clk;

    // Reference model state
    int m_mode, m_cnt, m_init;
    bit m_cp, m_rd, m_sd, m_running, m_stop, m_halt, m_pprev;
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_lvl [2];
    int m_ones [2];
    int m_zeros [2];

    task automatic model_edge();
        bit raw [2];
        bit prs [2];
        bit pe;
        bit was_cp;
        raw[0] = ifc.run_btn;
        raw[1] = ifc.step_btn;
        if (reset) begin
            m_mode = MInit; m_cp = 0; m_rd = 0; m_sd = 1; m_running = 0; m_cnt = 0;
            m_init = 0; m_stop = 0; m_halt = 0; m_pprev = 0;
            for (int b = 0; b < 2; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_ones[b] = 0; m_zeros[b] = 0;
            end
            return;
        end
        // Debounced level = value of the last DB synchronised samples when they all agree.
        for (int b = 0; b < 2; b++) begin
            if (m_s2[b]) begin
                if (m_ones[b] < 1000) m_ones[b]++;
                m_zeros[b] = 0;
            end else begin
                if (m_zeros[b] < 1000) m_zeros[b]++;
                m_ones[b] = 0;
            end
            prs[b] = 0;
            if (!m_lvl[b] && m_ones[b] >= DB) begin
                m_lvl[b] = 1;
                prs[b] = 1;
            end else if (m_lvl[b] && m_zeros[b] >= DB) begin
                m_lvl[b] = 0;
            end
            m_s2[b] = m_s1[b];
            m_s1[b] = raw[b];
        end
`ifdef STEP_CLOCK_PRESET_EN
        pe = ifc.preset_req && !m_pprev;
        m_pprev = ifc.preset_req;
`else
        pe = 0;
`endif
        was_cp = m_cp;
        m_sd = 1;
        case (m_mode)
            MInit: begin
                m_cp = 0;
                m_init++;
                if (m_init >= RC) begin
                    m_mode = MIdle;
                    m_rd = 1;
                end
            end
            MIdle: begin
                m_cp = 0;
                if (pe) m_sd = 0;
                else if (prs[0]) begin m_mode = MRun; m_cp = 1; m_stop = 0; m_halt = 0; end
                else if (prs[1]) begin m_mode = MStep; m_cp = 1; end
            end
            MRun: begin
                if (prs[0]) m_stop = 1;
                if (ifc.halt_req) m_halt = 1;
                if (m_cp) begin
                    m_cp = 0;
                    if (m_halt) m_mode = MHalt;
                    else if (m_stop) m_mode = MIdle;
                end else begin
                    m_cp = 1;
                end
            end
            MStep: begin
                m_cp = 0;
                m_mode = MIdle;
            end
            default: begin
                m_cp = 0;
                if (pe) m_sd = 0;
                else if (prs[0] && !ifc.halt_req) begin
                    m_mode = MRun; m_cp = 1; m_stop = 0; m_halt = 0;
                end else if (prs[1]) begin
                    m_mode = MStep; m_cp = 1;
                end
            end
        endcase
        if (m_cp && !was_cp) m_cnt = (m_cnt + 1) % 256;
        m_running = (m_mode == MRun);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_edge();
        end
    end

    // Per-cycle comparison against the model
    initial begin
        logic [11:0] exp_v, got_v;
        forever begin
            @(negedge clk);
            exp_v = {m_cp, m_rd, m_sd, m_running, 8'(m_cnt)};
            got_v = {ifc.cp, ifc._rd, ifc._sd, ifc.running, ifc.step_count};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t: got cp,rd,sd,run,cnt=%b expected %b",
                         $time, got_v, exp_v);
            end
            n_cmp++;
            if (ifc._rd !== 1'b1 && ifc._sd !== 1'b1) begin
                n_fail++;
                $display("FAIL rd_sd_low t=%0t: got rd=%b sd=%b, required not both 0",
                         $time, ifc._rd, ifc._sd);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic press_btn(input bit is_run, input int hold, input int after);
        if (is_run) ifc.run_btn = 1'b1; else ifc.step_btn = 1'b1;
        repeat (hold) @(negedge clk);
        ifc.run_btn = 1'b0;
        ifc.step_btn = 1'b0;
        repeat (after) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int c0, rises, k;
        bit prev_cp, found;
        int run_left, step_left, rst_left;
        ifc.run_btn = 1'b0;
        ifc.step_btn = 1'b0;
        ifc.halt_req = 1'b0;
`ifdef STEP_CLOCK_PRESET_EN
        ifc.preset_req = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset_rd", ifc._rd, 0);
        check("reset_cp", ifc.cp, 0);
        reset = 1'b0;

        // Power-up: _rd held low for RC clocks after release
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("pwr_rd_%0d", i), ifc._rd, (i == 4) ? 1 : 0);
        end
        check("pwr_cp", ifc.cp, 0);
        check("pwr_sd", ifc._sd, 1);
        check("pwr_cnt", ifc.step_count, 0);

        // Single step: cp high exactly on the 5th clock after the rise
        ifc.step_btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check($sformatf("step_cp_%0d", i), ifc.cp, (i == 5) ? 1 : 0);
        end
        ifc.step_btn = 1'b0;
        repeat (6) @(negedge clk);
        check("step_cnt", ifc.step_count, 1);

        // Short glitch is ignored
        press_btn(1'b0, 2, 10);
        check("glitch_cnt", ifc.step_count, 1);

        // Per-clock bounce never holds for DB samples
        c0 = ifc.step_count;
        for (int i = 0; i < 12; i++) begin
            ifc.step_btn = (i % 2 == 0);
            @(negedge clk);
        end
        ifc.step_btn = 1'b0;
        repeat (10) @(negedge clk);
        check("bounce_steps", int'(ifc.step_count) - c0, 0);

        // Free run for 300 cp rising edges from a fresh reset
        do_reset();
        ifc.run_btn = 1'b1;
        rises = 0;
        prev_cp = 1'b0;
        for (int cyc = 1; cyc <= 1200 && rises < 300; cyc++) begin
            @(negedge clk);
            if (cyc == 6) ifc.run_btn = 1'b0;
            if (ifc.cp && !prev_cp) rises++;
            prev_cp = ifc.cp;
        end
        check("run_rises", rises, 300);
        check("run_cnt_wrap", ifc.step_count, 44);
        check("run_running", ifc.running, 1);

        // Stop
        press_btn(1'b1, 6, 8);
        check("stop_running", ifc.running, 0);
        check("stop_cp", ifc.cp, 0);

        // Halt
        press_btn(1'b1, 6, 4);
        check("halt_pre_running", ifc.running, 1);
        ifc.halt_req = 1'b1;
        repeat (2) @(negedge clk);
        check("halt_cp", ifc.cp, 0);
        check("halt_running", ifc.running, 0);
        c0 = ifc.step_count;
        press_btn(1'b1, 6, 4);
        check("halt_run_ignored", ifc.running, 0);
        check("halt_run_cnt", int'(ifc.step_count) - c0, 0);
        press_btn(1'b0, 6, 4);
        check("halt_step_cnt", int'(ifc.step_count) - c0, 1);
        ifc.halt_req = 1'b0;
        press_btn(1'b1, 6, 2);
        check("halt_resume", ifc.running, 1);

        // Reset while cp is high
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = ifc.cp;
        end
        check("midpulse_found", found, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midpulse_cp", ifc.cp, 0);
        check("midpulse_rd", ifc._rd, 0);
        check("midpulse_cnt", ifc.step_count, 0);
        repeat (6) @(negedge clk);

`ifdef STEP_CLOCK_PRESET_EN
        ifc.preset_req = 1'b1;
        @(negedge clk);
        check("preset_sd", ifc._sd, 0);
        check("preset_rd", ifc._rd, 1);
        @(negedge clk);
        check("preset_sd_end", ifc._sd, 1);
        ifc.preset_req = 1'b0;
        press_btn(1'b1, 6, 2);
        ifc.preset_req = 1'b1;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (!ifc._sd) k++;
        end
        check("preset_run_ignored", k, 0);
        ifc.preset_req = 1'b0;
        press_btn(1'b1, 6, 4);
`endif

        // Random phase
        run_left = 0;
        step_left = 0;
        rst_left = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (run_left > 0) run_left--;
            else if ($urandom_range(0, 39) == 0) run_left = $urandom_range(1, 14);
            ifc.run_btn = (run_left > 0);
            if (step_left > 0) step_left--;
            else if ($urandom_range(0, 29) == 0) step_left = $urandom_range(1, 14);
            ifc.step_btn = (step_left > 0);
            if ($urandom_range(0, 59) == 0) ifc.halt_req = ~ifc.halt_req;
`ifdef STEP_CLOCK_PRESET_EN
            if ($urandom_range(0, 19) == 0) ifc.preset_req = ~ifc.preset_req;
`endif
            if (rst_left > 0) rst_left--;
            else if ($urandom_range(0, 799) == 0) rst_left = $urandom_range(1, 3);
            reset = (rst_left > 0);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
